regfile_sb: RTL and testbench

Parametrised multi-read-port integer register file with an integrated busy scoreboard, the next-generation architectural register file for the pipelined RISCV core. It holds NREG registers of XLEN bits with x0 hardwired to zero, and provides NRD independent combinational read ports and one clocked write-back port. Its scoreboard marks destination registers busy at issue and clears them at write-back, so the hazard unit can stall on pending producers such as LD.

---
 rtl/regfile_sb.sv | 121 ++++++++++++
 tb/tb_regfile_sb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a busy scoreboard; x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding under `REGFILE_SB_BYPASS_EN.

module regfile_sb_rdport #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic [AW-1:0]               i_addr,
  input  logic [DEPTH-1:0][XLEN-1:0]  i_rf,
  input  logic [DEPTH-1:0]            i_busy,
  input  logic                        i_fwd_en,
  input  logic [AW-1:0]               i_fwd_addr,
  input  logic [XLEN-1:0]             i_fwd_data,
  input  logic                        i_fwd_busy,
  output logic [XLEN-1:0]             o_data,
  output logic                        o_busy
);
  logic w_hit;
  assign w_hit  = i_fwd_en && (i_fwd_addr == i_addr);
  assign o_data = w_hit ? i_fwd_data : i_rf[i_addr];
  assign o_busy = w_hit ? i_fwd_busy : i_busy[i_addr];
endmodule

module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(NREG+1),
  localparam int DEPTH = 1 << AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    i_rd_addr,
  output logic [NRD*XLEN-1:0]  o_rd_data,
  output logic [NRD-1:0]       o_rd_busy,
  input  logic                 i_wb_en,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [XLEN-1:0]      i_wb_data,
  input  logic                 i_iss_en,
  input  logic [AW-1:0]        i_iss_addr,
  output logic [NREG-1:0]      o_busy_vec,
  output logic [CW-1:0]        o_busy_cnt
);
  function automatic logic f_valid(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  logic                       w_wb_v, w_iss_v;
  logic [DEPTH-1:0][XLEN-1:0] w_rf;
  logic [DEPTH-1:0]           w_busy;
  logic                       w_inc, w_dec;
  logic                       w_fwd_en, w_fwd_busy;
  logic [CW-1:0]              r_cnt;

  assign w_wb_v  = i_wb_en  && f_valid(i_wb_addr);
  assign w_iss_v = i_iss_en && f_valid(i_iss_addr);

  // Entry 0 and the padding above NREG read as constant zero / never busy.
  assign w_rf[0]   = '0;
  assign w_busy[0] = 1'b0;
  for (genvar g = NREG; g < DEPTH; g++) begin : g_pad
    assign w_rf[g]   = '0;
    assign w_busy[g] = 1'b0;
  end

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    logic [XLEN-1:0] r_q;
    logic            r_b;
    logic            w_wr, w_is;
    assign w_wr = w_wb_v  && (i_wb_addr  == AW'(g));
    assign w_is = w_iss_v && (i_iss_addr == AW'(g));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
        r_b <= 1'b0;
      end else begin
        if (w_wr) r_q <= i_wb_data;
        // A new producer issued in the write-back cycle keeps the register busy.
        if (w_is)      r_b <= 1'b1;
        else if (w_wr) r_b <= 1'b0;
      end
    end
    assign w_rf[g]   = r_q;
    assign w_busy[g] = r_b;
  end

  assign w_inc = w_iss_v && !w_busy[i_iss_addr];
  assign w_dec = w_wb_v && w_busy[i_wb_addr] &&
                 !(w_iss_v && (i_iss_addr == i_wb_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
  end

  assign o_busy_vec = w_busy[NREG-1:0];
  assign o_busy_cnt = r_cnt;

`ifdef REGFILE_SB_BYPASS_EN
  assign w_fwd_en = w_wb_v && rst_n;
`else
  assign w_fwd_en = 1'b0;
`endif
  assign w_fwd_busy = w_iss_v && (i_iss_addr == i_wb_addr);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_sb_rdport #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_rd (
      .i_addr     (i_rd_addr[k*AW +: AW]),
      .i_rf       (w_rf),
      .i_busy     (w_busy),
      .i_fwd_en   (w_fwd_en),
      .i_fwd_addr (i_wb_addr),
      .i_fwd_data (i_wb_data),
      .i_fwd_busy (w_fwd_busy),
      .o_data     (o_rd_data[k*XLEN +: XLEN]),
      .o_busy     (o_rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: table-driven vectors on a 32-entry instance,
// hand sequences for scoreboard fill, reset pulse and a 24-entry instance.
`timescale 1ns/1ps
module tb_regfile_sb;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-entry instance
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         wb_en, iss_en;
  logic [4:0]   wb_addr, iss_addr;
  logic [63:0]  wb_data;
  logic [31:0]  busy_vec;
  logic [5:0]   busy_cnt;

  // 24-entry instance
  logic [9:0]   r24_addr;
  logic [127:0] r24_data;
  logic [1:0]   r24_busy;
  logic         w24_en, i24_en;
  logic [4:0]   w24_addr, i24_addr;
  logic [63:0]  w24_data;
  logic [23:0]  b24_vec;
  logic [4:0]   b24_cnt;

  regfile_sb #(.XLEN(64), .NREG(32), .NRD(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_busy(rd_busy), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_busy_vec(busy_vec), .o_busy_cnt(busy_cnt));

  regfile_sb #(.XLEN(64), .NREG(24), .NRD(2)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .i_rd_addr(r24_addr), .o_rd_data(r24_data),
    .o_rd_busy(r24_busy), .i_wb_en(w24_en), .i_wb_addr(w24_addr), .i_wb_data(w24_data),
    .i_iss_en(i24_en), .i_iss_addr(i24_addr), .o_busy_vec(b24_vec), .o_busy_cnt(b24_cnt));

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [63:0] d0, d1;   // expected pre-edge read data (no forwarding)
    logic        b0, b1;
    logic [5:0]  cnt;
  } vec_t;

  localparam int NV = 16;
  localparam logic [63:0] C5 = 64'h0123_4567_89AB_CDEF;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wb_en = 1'b0; iss_en = 1'b0; w24_en = 1'b0; i24_en = 1'b0;
  endtask

  initial begin
    //         we   wa    wd          ie   ia    ra0   ra1   d0     d1     b0 b1 cnt
    vt[0]  = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd0, 5'd31,64'h0, 64'h0, 0, 0, 6'd0};
    vt[1]  = '{1'b1,5'd0, 64'hDEAD,   1'b1,5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 0, 0, 6'd0};
    vt[2]  = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 0, 0, 6'd0};
    vt[3]  = '{1'b1,5'd5, C5,         1'b0,5'd0, 5'd5, 5'd5, 64'h0, 64'h0, 0, 0, 6'd0};
    vt[4]  = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd5, 5'd5, C5,    C5,    0, 0, 6'd0};
    vt[5]  = '{1'b0,5'd0, 64'h0,      1'b1,5'd7, 5'd7, 5'd5, 64'h0, C5,    0, 0, 6'd0};
    vt[6]  = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd7, 5'd7, 64'h0, 64'h0, 1, 1, 6'd1};
    vt[7]  = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd7, 5'd7, 64'h0, 64'h0, 1, 1, 6'd1};
    vt[8]  = '{1'b1,5'd7, 64'd42,     1'b0,5'd0, 5'd7, 5'd7, 64'h0, 64'h0, 1, 1, 6'd1};
    vt[9]  = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd7, 5'd7, 64'd42,64'd42,0, 0, 6'd0};
    vt[10] = '{1'b0,5'd0, 64'h0,      1'b1,5'd9, 5'd9, 5'd9, 64'h0, 64'h0, 0, 0, 6'd0};
    vt[11] = '{1'b1,5'd9, 64'd7,      1'b1,5'd9, 5'd9, 5'd9, 64'h0, 64'h0, 1, 1, 6'd1};
    vt[12] = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd9, 5'd9, 64'd7, 64'd7, 1, 1, 6'd1};
    vt[13] = '{1'b1,5'd9, 64'd8,      1'b0,5'd0, 5'd5, 5'd9, C5,    64'd7, 0, 1, 6'd1};
    vt[14] = '{1'b1,5'd5, 64'h11,     1'b0,5'd0, 5'd9, 5'd5, 64'd8, C5,    0, 0, 6'd0};
    vt[15] = '{1'b0,5'd0, 64'h0,      1'b0,5'd0, 5'd5, 5'd0, 64'h11,64'h0, 0, 0, 6'd0};

    idle();
    wb_addr = '0; wb_data = '0; iss_addr = '0; rd_addr = '0;
    w24_addr = '0; w24_data = '0; i24_addr = '0; r24_addr = '0;

    // Reset state, sampled while rst_n is still low
    #12;
    chk("rst_cnt",  64'(busy_cnt), 64'd0);
    chk("rst_vec",  64'(busy_vec), 64'd0);
    chk("rst_data", rd_data[63:0], 64'd0);
    chk("rst24_cnt", 64'(b24_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      logic [63:0] ed0, ed1;
      logic        eb0, eb1;
      @(posedge clk); #1;
      wb_en = vt[i].we; wb_addr = vt[i].wa; wb_data = vt[i].wd;
      iss_en = vt[i].ie; iss_addr = vt[i].ia;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      ed0 = vt[i].d0; ed1 = vt[i].d1; eb0 = vt[i].b0; eb1 = vt[i].b1;
`ifdef REGFILE_SB_BYPASS_EN
      if (vt[i].we && vt[i].wa != 5'd0 && vt[i].wa == vt[i].ra0) begin
        ed0 = vt[i].wd; eb0 = vt[i].ie && (vt[i].ia == vt[i].wa);
      end
      if (vt[i].we && vt[i].wa != 5'd0 && vt[i].wa == vt[i].ra1) begin
        ed1 = vt[i].wd; eb1 = vt[i].ie && (vt[i].ia == vt[i].wa);
      end
`endif
      @(negedge clk);
      chk($sformatf("v%0d_d0", i),  rd_data[63:0],   ed0);
      chk($sformatf("v%0d_d1", i),  rd_data[127:64], ed1);
      chk($sformatf("v%0d_b0", i),  64'(rd_busy[0]), 64'(eb0));
      chk($sformatf("v%0d_b1", i),  64'(rd_busy[1]), 64'(eb1));
      chk($sformatf("v%0d_cnt", i), 64'(busy_cnt),   64'(vt[i].cnt));
    end
    chk("x0_never_busy", 64'(busy_vec[0]), 64'd0);

    // Fill the scoreboard x1..x31
    for (int a = 1; a < 32; a++) begin
      @(posedge clk); #1;
      wb_en = 1'b0; iss_en = 1'b1; iss_addr = 5'(a);
    end
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("fill_cnt", 64'(busy_cnt), 64'd31);
    chk("fill_vec", 64'(busy_vec), 64'hFFFF_FFFE);

    // x3 is already busy, so only the x4 clear takes effect
    @(posedge clk); #1;
    iss_en = 1'b1; iss_addr = 5'd3; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'h44;
    @(posedge clk); #1;
    // Both take effect here: set x4, clear x3 -> net 0
    iss_en = 1'b1; iss_addr = 5'd4; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h33;
    rd_addr = {5'd3, 5'd4};
    @(negedge clk);
    chk("iw1_cnt", 64'(busy_cnt), 64'd30);
    chk("iw1_vec", 64'(busy_vec), 64'hFFFF_FFEE);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("iw2_cnt", 64'(busy_cnt), 64'd30);
    chk("iw2_vec", 64'(busy_vec), 64'hFFFF_FFF6);
    chk("iw2_d4",  rd_data[63:0],   64'h44);
    chk("iw2_d3",  rd_data[127:64], 64'h33);
    chk("iw2_b4",  64'(rd_busy[0]), 64'd1);
    chk("iw2_b3",  64'(rd_busy[1]), 64'd0);

    // Asynchronous reset pulse between edges
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(busy_cnt), 64'd0);
    chk("arst_vec", 64'(busy_vec), 64'd0);
    chk("arst_d4",  rd_data[63:0], 64'd0);
    chk("arst_b4",  64'(rd_busy[0]), 64'd0);
    #1 rst_n = 1'b1;

    // NREG=24: address 30 is out of range
    @(posedge clk); #1;
    w24_en = 1'b1; w24_addr = 5'd30; w24_data = 64'hBAD0_BAD0; i24_en = 1'b1; i24_addr = 5'd30;
    r24_addr = {5'd23, 5'd30};
    @(negedge clk);
    chk("n24_wcyc_d30", r24_data[63:0], 64'd0);
    chk("n24_wcyc_b30", 64'(r24_busy[0]), 64'd0);
    @(posedge clk); #1;
    w24_en = 1'b0; i24_en = 1'b1; i24_addr = 5'd23;
    @(negedge clk);
    chk("n24_d30",   r24_data[63:0], 64'd0);
    chk("n24_b30",   64'(r24_busy[0]), 64'd0);
    chk("n24_cnt0",  64'(b24_cnt), 64'd0);
    chk("n24_vec0",  64'(b24_vec), 64'd0);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("n24_cnt1",  64'(b24_cnt), 64'd1);
    chk("n24_vec1",  64'(b24_vec), 64'h80_0000);
    chk("n24_b23",   64'(r24_busy[1]), 64'd1);
    chk("n24_b30b",  64'(r24_busy[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
